// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: a valid/ready command becomes one APB
// SETUP/ACCESS transfer whose status comes back on a valid/ready response.
module apb_master_bridge #(
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        apb_clk_in,
  input  logic                        apb_rstn_in,
  // Handshakes: a beat transfers on a rising edge where valid and ready are
  // both high; valid never waits on ready, and payload is held while
  // valid is high and ready is low.
  input  logic                        cmd_valid_in,
  output logic                        cmd_ready_out,
  input  logic [APB_ADDR_WIDTH-1:0]   cmd_addr_in,
  input  logic                        cmd_write_in,
  input  logic [APB_DATA_WIDTH-1:0]   cmd_wdata_in,
  input  logic [APB_DATA_WIDTH/8-1:0] cmd_strb_in,
  output logic                        rsp_valid_out,
  input  logic                        rsp_ready_in,
  output logic [APB_DATA_WIDTH-1:0]   rsp_rdata_out,
  output logic                        rsp_err_out,
  output logic                        rsp_timeout_out,
  output logic [APB_ADDR_WIDTH-1:0]   apb_addr_out,
  output logic                        apb_write_out,
  output logic [APB_DATA_WIDTH-1:0]   apb_wdata_out,
  output logic [APB_DATA_WIDTH/8-1:0] apb_strb_out,
  output logic                        apb_psel_out,
  output logic                        apb_penable_out,
  input  logic [APB_DATA_WIDTH-1:0]   apb_rdata_in,
  input  logic                        apb_ready_in,
  input  logic                        apb_slverr_in
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic             TO_EN    = (TIMEOUT_CYCLES > 0);

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    SETUP  = 4'b0010,
    ACCESS = 4'b0100,
    RESP   = 4'b1000
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] acc_cnt;
  logic             cmd_fire;
  logic             rsp_fire;
  logic             ready_hit;
  logic             timeout_hit;

  // cmd_ready_out is high only while in IDLE, so a fire implies IDLE.
  assign cmd_fire    = cmd_ready_out & cmd_valid_in;
  assign rsp_fire    = rsp_valid_out & rsp_ready_in;
  assign ready_hit   = (state == ACCESS) & apb_ready_in;
  assign timeout_hit = (state == ACCESS) & ~apb_ready_in & TO_EN & (acc_cnt == TO_LIMIT);

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_fire) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (ready_hit || timeout_hit) state_next = RESP;
      RESP:    if (rsp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and APB strobes are registered from the next state so that
  // every output is low during reset and cmd_ready rises one clock later.
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      cmd_ready_out   <= 1'b0;
      apb_psel_out    <= 1'b0;
      apb_penable_out <= 1'b0;
      rsp_valid_out   <= 1'b0;
    end else begin
      cmd_ready_out   <= (state_next == IDLE);
      apb_psel_out    <= (state_next == SETUP) || (state_next == ACCESS);
      apb_penable_out <= (state_next == ACCESS);
      rsp_valid_out   <= (state_next == RESP);
    end
  end

  // Access counter: 1 in the first ACCESS cycle, saturating.
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      acc_cnt <= '0;
    end else if (state == SETUP) begin
      acc_cnt <= CNT_W'(1);
    end else if ((state == ACCESS) && (acc_cnt != CNT_MAX)) begin
      acc_cnt <= acc_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      apb_addr_out  <= '0;
      apb_write_out <= 1'b0;
      apb_wdata_out <= '0;
      apb_strb_out  <= '0;
    end else if (cmd_fire) begin
      apb_addr_out  <= cmd_addr_in;
      apb_write_out <= cmd_write_in;
      apb_wdata_out <= cmd_write_in ? cmd_wdata_in : '0;
      apb_strb_out  <= cmd_write_in ? cmd_strb_in : '0;
    end
  end

  // PREADY is checked first so it wins over a simultaneous timeout.
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      rsp_rdata_out   <= '0;
      rsp_err_out     <= 1'b0;
      rsp_timeout_out <= 1'b0;
    end else if (ready_hit) begin
      rsp_rdata_out   <= apb_write_out ? '0 : apb_rdata_in;
      rsp_err_out     <= apb_slverr_in;
      rsp_timeout_out <= 1'b0;
    end else if (timeout_hit) begin
      rsp_rdata_out   <= '0;
      rsp_err_out     <= 1'b1;
      rsp_timeout_out <= 1'b1;
    end
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Single-outstanding APB initiator that converts a valid/ready command interface into APB SETUP/ACCESS transfers and returns read data and error status on a valid/ready response interface. It drives the APB slave side of the peripheral register blocks (UART/SPI register files) from a host-side sequencer, test engine or CPU shim. It inserts no extra wait states beyond the APB minimum, and it bounds every transfer with an optional PREADY timeout.

## Interface
- APB_DATA_WIDTH, 32, width of the write and read data buses.
- APB_ADDR_WIDTH, 32, width of the address bus.
- TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles without PREADY before abort. 0 disables the timeout.
- apb_clk_in  in  1  clock; all logic is on the rising edge.
- apb_rstn_in  in  1  reset, asynchronous, active-low.
- cmd_valid_in  in  1  command request.
- cmd_ready_out  out  1  command accepted when high together with cmd_valid_in.
- cmd_addr_in  in  APB_ADDR_WIDTH  transfer address.
- cmd_write_in  in  1  1 = write, 0 = read.
- cmd_wdata_in  in  APB_DATA_WIDTH  write data.
- cmd_strb_in  in  APB_DATA_WIDTH/8  write byte strobes.
- rsp_valid_out  out  1  response available.
- rsp_ready_in  in  1  response consumed when high together with rsp_valid_out.
- rsp_rdata_out  out  APB_DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err_out  out  1  the slave returned PSLVERR, or the transfer timed out.
- rsp_timeout_out  out  1  the transfer was aborted by the timeout.
- apb_addr_out, apb_write_out, apb_wdata_out, apb_strb_out  out  per parameter  APB address and control.
- apb_psel_out, apb_penable_out  out  1  APB select and enable.
- apb_rdata_in  in  APB_DATA_WIDTH  APB read data.
- apb_ready_in  in  1  APB PREADY.
- apb_slverr_in  in  1  APB PSLVERR.

## Operation
- The FSM has four states, one-hot encoded: IDLE, SETUP, ACCESS, RESP. Reset enters IDLE.
- IDLE:
  - cmd_ready_out = 1.
  - On cmd_valid_in, register addr/write/wdata/strb onto the APB outputs and go to SETUP.
  - For reads, apb_strb_out = 0 and apb_wdata_out = 0.
- SETUP: psel = 1, penable = 0, for exactly one cycle, then go to ACCESS.
- ACCESS:
  - psel = 1, penable = 1. Address, control and data stay stable.
  - The access counter starts at 1 in the first ACCESS cycle.
  - When apb_ready_in = 1 is sampled:
    - capture rsp_rdata_out = apb_rdata_in for reads (0 for writes);
    - capture rsp_err_out = apb_slverr_in and rsp_timeout_out = 0;
    - go to RESP.
  - When the counter equals TIMEOUT_CYCLES with apb_ready_in = 0:
    - set rsp_err_out = 1, rsp_timeout_out = 1, rsp_rdata_out = 0;
    - go to RESP.
  - If PREADY is high in the same cycle the timeout would fire, PREADY wins.
- RESP:
  - psel = 0, penable = 0, rsp_valid_out = 1.
  - Response fields hold until rsp_ready_in is sampled high, then go to IDLE.
- apb_slverr_in is ignored outside an ACCESS cycle with apb_ready_in = 1.
- The APB address and control outputs hold their last values outside transfers. Only psel/penable qualify them.
- Counter width is clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.

## Timing
- Every output resets to 0, including cmd_ready_out (it rises on the first clock after reset release).
- Command accepted at edge N: SETUP during N..N+1, first ACCESS during N+1..N+2.
- Zero-wait-state slave: PREADY is sampled at edge N+2, and rsp_valid_out is high after edge N+2.
- Each PREADY-low cycle adds one cycle of latency.
- With rsp_ready_in held high, a response is consumed one cycle after it appears. cmd_ready_out reasserts the cycle after that. Back-to-back issue is therefore one transfer per 4 cycles.
- Reset asserted mid-transfer immediately clears psel, penable and rsp_valid_out. The transfer is dropped with no response.
- Command inputs are don't-care except in IDLE.

## Test plan
- Write, zero wait state: addr 0xA0300004, wdata 0x00000800, strb 0xF -> psel high for 2 cycles, penable high for 1 cycle, pwrite = 1; response rdata = 0, err = 0.
- Read with 3 wait states: PREADY low for 3 ACCESS cycles, then high with prdata 0x5A -> ACCESS lasts 4 cycles; response rdata = 0x5A, err = 0.
- Slave error: write with PSLVERR = 1 and PREADY = 1 in the first ACCESS cycle -> err = 1, timeout = 0.
- Timeout with TIMEOUT_CYCLES = 16 and PREADY stuck low -> abort after 16 ACCESS cycles; err = 1, timeout = 1, rdata = 0, psel low the next cycle.
- Timeout boundary: PREADY rises exactly on ACCESS cycle 16 -> normal completion, timeout = 0.
- Response backpressure and reset:
  - hold rsp_ready_in low for 5 cycles -> response held stable, cmd_ready_out stays low;
  - assert reset during ACCESS -> all outputs 0 and no response issued.
